dpll_data_separator: RTL

//   Parametrised digital-PLL floppy data separator; successor to the phase-jerked loop.

---
 rtl/dpll_pkg.sv | 10 +
 rtl/flux_edge_sync.sv | 41 ++++
 rtl/dpll_data_separator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared constants for the DPLL data separator: correction-mode encodings and
// the smallest bitcell period the loop will accept.
package dpll_pkg;

  localparam logic MODE_JERK = 1'b0;
  localparam logic MODE_PROP = 1'b1;

  localparam int unsigned MIN_PERIOD = 4;

endpackage

// File: rtl/flux_edge_sync.sv
// Synchronises the asynchronous RDDATA flux line and turns each rising
// transition into a 1-clock EDGE pulse plus a 2-clock shaped pulse.
module flux_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rddata,
  output logic o_edge,
  output logic o_shaped
);

  // Depths below two are not metastability-safe, so they are raised to two.
  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SS-1:0] r_sync;
  logic          r_last;
  logic          r_edge;
  logic          r_shaped;
  logic          w_rise;

  assign w_rise = r_sync[SS-1] & ~r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_last   <= 1'b0;
      r_edge   <= 1'b0;
      r_shaped <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SS-2:0], i_rddata};
      r_last   <= r_sync[SS-1];
      r_edge   <= w_rise;
      r_shaped <= w_rise | r_edge;
    end
  end

  assign o_edge   = r_edge;
  assign o_shaped = r_shaped;

endmodule

// File: rtl/dpll_data_separator.sv
// Digital-PLL floppy data separator: windows the synchronised flux edges into
// bitcells, with jerk or proportional phase correction and lock detection.
module dpll_data_separator
  import dpll_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEFAULT_PERIOD = 32,
  parameter int unsigned GAIN_SHIFT     = 1,
  parameter int unsigned LOCK_TOL       = 2,
  parameter int unsigned LOCK_COUNT     = 16
) (
  input  logic                 MASTER_CLK,
  input  logic                 RESET_N,
  input  logic                 CLKEN,
  input  logic                 FD_RDDATA_IN,
  input  logic [CNT_WIDTH-1:0] PERIOD,
  input  logic                 MODE,
  output logic                 SHAPED_DATA,
  output logic                 DWIN,
  output logic                 BIT_STROBE,
  output logic                 RD_BIT,
  output logic                 LOCKED,
  output logic [CNT_WIDTH-1:0] PHASE_ERR
);

  localparam int unsigned CW = CNT_WIDTH;
  localparam int unsigned EW = CW + 1;
  localparam int unsigned XW = CW + 2;
  localparam int unsigned GS = (GAIN_SHIFT < 1) ? 1 : GAIN_SHIFT;
  localparam int unsigned LW = $clog2(LOCK_COUNT + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_per;
  logic          r_pend;
  logic          r_flag;
  logic [LW-1:0] r_lock_cnt;
  logic          r_dwin;
  logic          r_strobe;
  logic          r_rd_bit;
  logic          r_locked;
  logic [CW-1:0] r_phase_err;

  logic                 w_edge;
  logic                 w_shaped;
  logic                 w_pend;
  logic                 w_wrap;
  logic                 w_in_tol;
  logic [CW-1:0]        w_half;
  logic [CW-1:0]        w_new_per;
  logic [CW-1:0]        w_prop_clamped;
  logic [CW-1:0]        w_cnt_nxt;
  logic signed [EW-1:0] w_err;
  logic [EW-1:0]        w_abs_err;
  logic signed [XW-1:0] w_cnt_x;
  logic signed [XW-1:0] w_err_x;
  logic signed [XW-1:0] w_corr;
  logic signed [XW-1:0] w_prop;
  logic signed [XW-1:0] w_prop_max;

  flux_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (MASTER_CLK),
    .i_rst_n (RESET_N),
    .i_rddata(FD_RDDATA_IN),
    .o_edge  (w_edge),
    .o_shaped(w_shaped)
  );

  // An edge arriving on a CLKEN cycle is consumed in that same cycle.
  assign w_pend    = r_pend | w_edge;
  assign w_half    = r_per >> 1;
  assign w_err     = $signed({1'b0, r_cnt}) - $signed({1'b0, w_half});
  assign w_abs_err = w_err[EW-1] ? EW'(-w_err) : EW'(w_err);
  assign w_in_tol  = (w_abs_err <= EW'(LOCK_TOL));
  assign w_new_per = (PERIOD < CW'(MIN_PERIOD)) ? CW'(MIN_PERIOD) : PERIOD;

  // >= rather than == so a jerk target beyond a freshly shortened period still wraps.
  assign w_wrap = (r_cnt >= (r_per - CW'(1)));

  assign w_cnt_x    = {2'b00, r_cnt};
  assign w_err_x    = {w_err[EW-1], w_err};
  assign w_corr     = w_err_x >>> GS;
  assign w_prop     = w_cnt_x + XW'(1) - w_corr;
  assign w_prop_max = {2'b00, r_per - CW'(1)};

  // Proportional target clamped into the current window.
  always_comb begin
    w_prop_clamped = w_prop[CW-1:0];
    if (w_prop < 0) begin
      w_prop_clamped = '0;
    end else if (w_prop > w_prop_max) begin
      w_prop_clamped = r_per - CW'(1);
    end
  end

  always_comb begin
    w_cnt_nxt = w_wrap ? '0 : (r_cnt + CW'(1));
    if (w_pend) begin
      w_cnt_nxt = (MODE == MODE_PROP) ? w_prop_clamped : (w_half + CW'(1));
    end
  end

  always_ff @(posedge MASTER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt       <= '0;
      r_per       <= CW'(DEFAULT_PERIOD);
      r_pend      <= 1'b0;
      r_flag      <= 1'b0;
      r_lock_cnt  <= '0;
      r_dwin      <= 1'b0;
      r_strobe    <= 1'b0;
      r_rd_bit    <= 1'b0;
      r_locked    <= 1'b0;
      r_phase_err <= '0;
    end else begin
      r_dwin   <= 1'b0;
      r_strobe <= 1'b0;
      if (CLKEN) begin
        r_cnt  <= w_cnt_nxt;
        r_dwin <= (r_cnt == w_half);
        r_pend <= 1'b0;
        // A boundary edge belongs to the closing window, not the next one.
        if (w_wrap) begin
          r_strobe <= 1'b1;
          r_rd_bit <= r_flag | w_pend;
          r_flag   <= 1'b0;
          r_per    <= w_new_per;
        end else if (w_pend) begin
          r_flag <= 1'b1;
        end
        if (w_pend) begin
          r_phase_err <= w_err[CW-1:0];
          if (w_in_tol) begin
            if (r_lock_cnt < LW'(LOCK_COUNT)) begin
              r_lock_cnt <= r_lock_cnt + LW'(1);
            end
            if (r_lock_cnt >= LW'(LOCK_COUNT - 1)) begin
              r_locked <= 1'b1;
            end
          end else begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
          end
        end
      end else begin
        r_pend <= w_pend;
      end
    end
  end

  assign SHAPED_DATA = w_shaped;
  assign DWIN        = r_dwin;
  assign BIT_STROBE  = r_strobe;
  assign RD_BIT      = r_rd_bit;
  assign LOCKED      = r_locked;
  assign PHASE_ERR   = r_phase_err;

endmodule
